// File: rtl/ipsxe_floating_point_invsqrt_pkg.sv
// Shared sizing helpers for the inverse-square-root datapath: z/output width
// derivation and the number of product LSBs dropped ahead of the RNE stage.
package ipsxe_floating_point_invsqrt_pkg;

  localparam int DLT_BITS = 17;

  function automatic int calc_zw(input int man_w, input int rne, input int rne1);
    return ((man_w + 1) + rne + rne1) / 2;
  endfunction

  function automatic int calc_ow(input int zw, input int rne2);
    return zw + rne2 - DLT_BITS;
  endfunction

  // Lower half gets the extra bit when a width is odd.
  function automatic int ceil_half(input int w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_pp4_mult_v1_0.sv
// Stage-1 of the z*group1 multiplier: splits both operands into halves and
// registers the four partial products together with their valid bit.
module ipsxe_floating_point_pp4_mult_v1_0
  import ipsxe_floating_point_invsqrt_pkg::*;
#(
  parameter int  ZW = 52,
  parameter int  GW = 44,
  localparam int ZL = ceil_half(ZW),
  localparam int ZH = ZW - ZL,
  localparam int GL = ceil_half(GW),
  localparam int GH = GW - GL
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ce,
  input  logic               i_valid,
  input  logic [ZW-1:0]      i_z,
  input  logic [GW-1:0]      i_g,
  output logic               o_vld_p1,
  output logic [ZL+GL-1:0]   o_pp_ll_p1,
  output logic [ZL+GH-1:0]   o_pp_lh_p1,
  output logic [ZH+GL-1:0]   o_pp_hl_p1,
  output logic [ZH+GH-1:0]   o_pp_hh_p1
);

  logic [ZL-1:0] z_lo;
  logic [ZH-1:0] z_hi;
  logic [GL-1:0] g_lo;
  logic [GH-1:0] g_hi;

  logic             vld_p1_d, vld_p1_q;
  logic [ZL+GL-1:0] pp_ll_p1_d, pp_ll_p1_q;
  logic [ZL+GH-1:0] pp_lh_p1_d, pp_lh_p1_q;
  logic [ZH+GL-1:0] pp_hl_p1_d, pp_hl_p1_q;
  logic [ZH+GH-1:0] pp_hh_p1_d, pp_hh_p1_q;

  assign z_lo = i_z[ZL-1:0];
  assign z_hi = i_z[ZW-1:ZL];
  assign g_lo = i_g[GL-1:0];
  assign g_hi = i_g[GW-1:GL];

  always_comb begin
    vld_p1_d   = vld_p1_q;
    pp_ll_p1_d = pp_ll_p1_q;
    pp_lh_p1_d = pp_lh_p1_q;
    pp_hl_p1_d = pp_hl_p1_q;
    pp_hh_p1_d = pp_hh_p1_q;
    if (i_ce) begin
      vld_p1_d = i_valid;
      if (i_valid) begin
        pp_ll_p1_d = {{GL{1'b0}}, z_lo} * {{ZL{1'b0}}, g_lo};
        pp_lh_p1_d = {{GH{1'b0}}, z_lo} * {{ZL{1'b0}}, g_hi};
        pp_hl_p1_d = {{GL{1'b0}}, z_hi} * {{ZH{1'b0}}, g_lo};
        pp_hh_p1_d = {{GH{1'b0}}, z_hi} * {{ZH{1'b0}}, g_hi};
      end
    end
  end

  // Stage 1 boundary: partial products
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1_q   <= 1'b0;
      pp_ll_p1_q <= '0;
      pp_lh_p1_q <= '0;
      pp_hl_p1_q <= '0;
      pp_hh_p1_q <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      pp_ll_p1_q <= pp_ll_p1_d;
      pp_lh_p1_q <= pp_lh_p1_d;
      pp_hl_p1_q <= pp_hl_p1_d;
      pp_hh_p1_q <= pp_hh_p1_d;
    end
  end

  assign o_vld_p1   = vld_p1_q;
  assign o_pp_ll_p1 = pp_ll_p1_q;
  assign o_pp_lh_p1 = pp_lh_p1_q;
  assign o_pp_hl_p1 = pp_hl_p1_q;
  assign o_pp_hh_p1 = pp_hh_p1_q;

endmodule

// File: rtl/ipsxe_floating_point_z_group1_mult_v1_0.sv
// Three-stage exact z*group1 multiplier; emits product bits above DLT_BITS.
// Define IPSXE_FLOATING_POINT_LSB_NZ_EN to produce o_lsb_nz (sticky of dropped bits).
module ipsxe_floating_point_z_group1_mult_v1_0
  import ipsxe_floating_point_invsqrt_pkg::*;
#(
  parameter int  MAN_WIDTH = 52,
  parameter int  RNE       = 2,
  parameter int  RNE1      = 49,
  parameter int  RNE2      = 44,
  localparam int ZW        = calc_zw(MAN_WIDTH, RNE, RNE1),
  localparam int OW        = calc_ow(ZW, RNE2)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ce,
  input  logic            i_valid,
  input  logic [ZW-1:0]   i_z,
  input  logic [RNE2-1:0] i_group1,
  output logic            o_valid,
  output logic [OW-1:0]   o_z_group1_rne2_dlt17zeros,
  output logic            o_lsb_nz
);

  localparam int PW = ZW + RNE2;
  localparam int ZL = ceil_half(ZW);
  localparam int ZH = ZW - ZL;
  localparam int GL = ceil_half(RNE2);
  localparam int GH = RNE2 - GL;

  logic             vld_p1;
  logic [ZL+GL-1:0] pp_ll_p1;
  logic [ZL+GH-1:0] pp_lh_p1;
  logic [ZH+GL-1:0] pp_hl_p1;
  logic [ZH+GH-1:0] pp_hh_p1;

  ipsxe_floating_point_pp4_mult_v1_0 #(
    .ZW (ZW),
    .GW (RNE2)
  ) u_pp4 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ce       (i_ce),
    .i_valid    (i_valid),
    .i_z        (i_z),
    .i_g        (i_group1),
    .o_vld_p1   (vld_p1),
    .o_pp_ll_p1 (pp_ll_p1),
    .o_pp_lh_p1 (pp_lh_p1),
    .o_pp_hl_p1 (pp_hl_p1),
    .o_pp_hh_p1 (pp_hh_p1)
  );

  logic          vld_p2_d, vld_p2_q;
  logic [PW-1:0] sum_p2_d, sum_p2_q;
  logic          vld_p3_d, vld_p3_q;
  logic [OW-1:0] out_p3_d, out_p3_q;

  always_comb begin
    vld_p2_d = vld_p2_q;
    sum_p2_d = sum_p2_q;
    if (i_ce) begin
      vld_p2_d = vld_p1;
      if (vld_p1) begin
        sum_p2_d = PW'(pp_ll_p1)
                 + (PW'(pp_lh_p1) << GL)
                 + (PW'(pp_hl_p1) << ZL)
                 + (PW'(pp_hh_p1) << (ZL + GL));
      end
    end
  end

  always_comb begin
    vld_p3_d = vld_p3_q;
    out_p3_d = out_p3_q;
    if (i_ce) begin
      vld_p3_d = vld_p2_q;
      if (vld_p2_q) begin
        out_p3_d = sum_p2_q[PW-1:DLT_BITS];
      end
    end
  end

  // Stage 2 boundary: full product; stage 3 boundary: truncated output slice
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p2_q <= 1'b0;
      sum_p2_q <= '0;
      vld_p3_q <= 1'b0;
      out_p3_q <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      sum_p2_q <= sum_p2_d;
      vld_p3_q <= vld_p3_d;
      out_p3_q <= out_p3_d;
    end
  end

`ifdef IPSXE_FLOATING_POINT_LSB_NZ_EN
  logic lsb_nz_p3_d, lsb_nz_p3_q;

  always_comb begin
    lsb_nz_p3_d = lsb_nz_p3_q;
    if (i_ce && vld_p2_q) begin
      lsb_nz_p3_d = |sum_p2_q[DLT_BITS-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lsb_nz_p3_q <= 1'b0;
    end else begin
      lsb_nz_p3_q <= lsb_nz_p3_d;
    end
  end

  assign o_lsb_nz = lsb_nz_p3_q;
`else
  // Dropped bits have no consumer in this build; synthesis prunes them.
  logic lsb_unused;
  assign lsb_unused = |sum_p2_q[DLT_BITS-1:0];
  assign o_lsb_nz   = 1'b0;
`endif

  assign o_valid                    = vld_p3_q;
  assign o_z_group1_rne2_dlt17zeros = out_p3_q;

endmodule

// File: tb/tb_ipsxe_floating_point_z_group1_mult_v1_0.sv
// Self-checking bench for ipsxe_floating_point_z_group1_mult_v1_0 (default parameters).
// Expectations follow IPSXE_FLOATING_POINT_LSB_NZ_EN when it is defined for the build.
module tb_ipsxe_floating_point_z_group1_mult_v1_0;

  localparam int ZW = 52;
  localparam int GW = 44;
  localparam int OW = 79;
  localparam int PW = ZW + GW;

`ifdef IPSXE_FLOATING_POINT_LSB_NZ_EN
  localparam bit LSB_EN = 1'b1;
`else
  localparam bit LSB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_ce;
  logic          i_valid;
  logic [ZW-1:0] i_z;
  logic [GW-1:0] i_group1;
  logic          o_valid;
  logic [OW-1:0] o_z;
  logic          o_lsb_nz;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  logic [OW-1:0] exp_out_q[$];
  logic          exp_lsb_q[$];

  always #5 clk = ~clk;

  ipsxe_floating_point_z_group1_mult_v1_0 dut (
    .i_clk                      (clk),
    .i_rst                      (i_rst),
    .i_ce                       (i_ce),
    .i_valid                    (i_valid),
    .i_z                        (i_z),
    .i_group1                   (i_group1),
    .o_valid                    (o_valid),
    .o_z_group1_rne2_dlt17zeros (o_z),
    .o_lsb_nz                   (o_lsb_nz)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, then drop the 17 low bits.
  task automatic model_push(input logic [ZW-1:0] z, input logic [GW-1:0] g);
    logic [PW-1:0] p;
    p = PW'(z) * PW'(g);
    exp_out_q.push_back(p / (PW'(1) << 17));
    exp_lsb_q.push_back(LSB_EN && ((p % (PW'(1) << 17)) != 0));
  endtask

  task automatic tick(input logic ce_v, input logic vld_v, input logic [ZW-1:0] z_v,
                      input logic [GW-1:0] g_v, input logic rst_v);
    logic          pv;
    logic [OW-1:0] pd;
    logic          pl;
    i_ce = ce_v; i_valid = vld_v; i_z = z_v; i_group1 = g_v; i_rst = rst_v;
    pv = o_valid; pd = o_z; pl = o_lsb_nz;
    @(posedge clk);
    if (rst_v) begin
      exp_out_q.delete();
      exp_lsb_q.delete();
    end else if (ce_v && vld_v) begin
      model_push(z_v, g_v);
    end
    #1;
    if (!rst_v && !ce_v) begin
      chk("hold_valid", 128'(o_valid), 128'(pv));
      chk("hold_data", 128'(o_z), 128'(pd));
      chk("hold_lsb", 128'(o_lsb_nz), 128'(pl));
    end else if (!rst_v && o_valid) begin
      n_out++;
      if (exp_out_q.size() == 0) begin
        chk("spurious_valid", 128'(o_valid), 128'(0));
      end else begin
        chk("model_data", 128'(o_z), 128'(exp_out_q.pop_front()));
        chk("model_lsb", 128'(o_lsb_nz), 128'(exp_lsb_q.pop_front()));
      end
    end
  endtask

  // Issue one operand into an empty pipe and check exact latency and value.
  task automatic directed(input string tag, input logic [ZW-1:0] z, input logic [GW-1:0] g,
                          input logic [OW-1:0] e_out, input logic e_lsb);
    tick(1'b1, 1'b1, z, g, 1'b0);
    chk({tag, "_lat1"}, 128'(o_valid), 128'(0));
    tick(1'b1, 1'b0, '0, '0, 1'b0);
    chk({tag, "_lat2"}, 128'(o_valid), 128'(0));
    tick(1'b1, 1'b0, '0, '0, 1'b0);
    chk({tag, "_valid"}, 128'(o_valid), 128'(1));
    chk({tag, "_data"}, 128'(o_z), 128'(e_out));
    chk({tag, "_lsb"}, 128'(o_lsb_nz), 128'(e_lsb));
  endtask

  initial begin
    logic [OW-1:0] e37;
    logic [63:0]   rz, rg;
    int            issued;
    int            cycles;

    i_rst = 1'b1; i_ce = 1'b0; i_valid = 1'b0; i_z = '0; i_group1 = '0;
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    chk("reset_valid", 128'(o_valid), 128'(0));
    chk("reset_data", 128'(o_z), 128'(0));
    chk("reset_lsb", 128'(o_lsb_nz), 128'(0));
    tick(1'b1, 1'b0, '0, '0, 1'b0);

    directed("one_x_one", 52'd1, 44'd1, '0, LSB_EN);
    directed("two17", 52'd1 << 17, 44'd1, 79'd1, 1'b0);
    directed("zero_z", 52'd0, {GW{1'b1}}, '0, 1'b0);
    e37 = '0;
    e37 = e37 - (79'd1 << 35) - (79'd1 << 27);
    directed("max_max", {ZW{1'b1}}, {GW{1'b1}}, e37, LSB_EN);

    // Reset (with i_ce low) while two operands are in flight and a third is offered.
    tick(1'b1, 1'b1, 52'h123456789ABCD, 44'hFEDCBA98765, 1'b0);
    tick(1'b1, 1'b1, {ZW{1'b1}}, 44'h00000000FFF, 1'b0);
    tick(1'b0, 1'b1, 52'hABCDEF0123456, 44'h13579BDF024, 1'b1);
    chk("midrst_valid", 128'(o_valid), 128'(0));
    chk("midrst_data", 128'(o_z), 128'(0));
    chk("midrst_lsb", 128'(o_lsb_nz), 128'(0));
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, '0, '0, 1'b0);
      chk("post_rst_quiet", 128'(o_valid), 128'(0));
    end
    directed("after_rst", 52'd3 << 20, 44'd5, 79'd15 << 3, 1'b0);

    // Back-to-back random operands with a randomly gated pipeline.
    n_out  = 0;
    issued = 0;
    cycles = 0;
    while (issued < 100 && cycles < 2000) begin
      logic ce_r;
      rz = {$urandom(), $urandom()};
      rg = {$urandom(), $urandom()};
      ce_r = ($urandom_range(0, 3) != 0);
      tick(ce_r, 1'b1, rz[ZW-1:0], rg[GW-1:0], 1'b0);
      if (ce_r) issued++;
      cycles++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, '0, '0, 1'b0);
    end
    chk("random_issued", 128'(issued), 128'(100));
    chk("random_out_count", 128'(n_out), 128'(100));
    chk("random_drained", 128'(exp_out_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
